sram_port_arbiter: RTL and testbench



---
 rtl/sram_port_arbiter_pkg.sv | 25 ++
 rtl/sram_port_arbiter_if.sv | 53 +++++
 rtl/sram_port_arbiter_pick.sv | 33 +++
 rtl/sram_port_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the unified-SRAM port arbiter: FSM state, port owner,
// counter widths and the saturating run-counter helper.
package sram_port_arbiter_pkg;

    localparam int CNT_W = 3;   // holds SRAM_LAT-1 for SRAM_LAT up to 7
    localparam int RUN_W = 4;   // holds MAX_DATA_RUN up to 15

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ACC  = 2'd1,
        ARB_WAIT = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    function automatic logic [RUN_W-1:0] run_inc_sat(input logic [RUN_W-1:0] run,
                                                     input logic [RUN_W-1:0] max_run);
        return (run >= max_run) ? max_run : run + RUN_W'(1);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the fetch port, data port, SRAM port and stall requests around
// the arbiter; slave is the arbiter side, master is the surrounding pipeline/SRAM.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // Handshake: *_req is a level held with stable fields until the matching
    // *_ack pulses for one cycle; fields are sampled only when the request is
    // granted, and a request still high after its ack is a new request.
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_ack;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic [BE_W-1:0]   data_wen;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_ack;
    logic [DATA_W-1:0] data_rdata;

    logic              sram_en;
    logic [BE_W-1:0]   sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    logic              stallreq_if;
    logic              stallreq_mem;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wen, data_addr, data_wdata,
        input  sram_rdata,
        output inst_ack, inst_rdata,
        output data_ack, data_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata,
        output stallreq_if, stallreq_mem
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wen, data_addr, data_wdata,
        output sram_rdata,
        input  inst_ack, inst_rdata,
        input  data_ack, data_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        input  stallreq_if, stallreq_mem
    );

endinterface

// File: rtl/sram_port_arbiter_pick.sv
// Combinational port priority: data first, except that a pending fetch wins
// once MAX_DATA_RUN data grants have gone by; also yields the next run count.
module sram_arb_pick
    import sram_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic             inst_req,
    input  logic             data_req,
    input  logic [RUN_W-1:0] data_run,
    output logic             grant_inst,
    output logic             grant_data,
    output logic [RUN_W-1:0] data_run_next
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    logic run_full;

    always_comb begin
        run_full      = (data_run >= RUN_MAX);
        grant_inst    = inst_req && (!data_req || run_full);
        grant_data    = data_req && !grant_inst;
        data_run_next = data_run;
        // The run only counts data grants that actually made a fetch wait.
        if (!inst_req || grant_inst) begin
            data_run_next = '0;
        end else if (grant_data) begin
            data_run_next = run_inc_sat(data_run, RUN_MAX);
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one fixed-latency single-port SRAM between instruction fetch and data
// access: arbitrate, enable for one cycle, wait out the latency, ack with data.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int SRAM_LAT     = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    sram_port_arbiter_if.slave bus,
    output arb_state_e        dbg_state,
    output logic [RUN_W-1:0]  dbg_data_run
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [BE_W-1:0]   wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [RUN_W-1:0]  data_run_q, data_run_d;

    logic              grant_inst;
    logic              grant_data;
    logic [RUN_W-1:0]  data_run_next;

    sram_arb_pick #(
        .MAX_DATA_RUN(MAX_DATA_RUN)
    ) u_pick (
        .inst_req      (bus.inst_req),
        .data_req      (bus.data_req),
        .data_run      (data_run_q),
        .grant_inst    (grant_inst),
        .grant_data    (grant_data),
        .data_run_next (data_run_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_INST;
            wen_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            cap_q      <= '0;
            data_run_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            data_run_q <= data_run_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wen_d      = wen_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        data_run_d = bus.inst_req ? data_run_q : '0;
        unique case (state_q)
            ARB_IDLE, ARB_RESP: begin
                if (grant_data) begin
                    state_d    = ARB_ACC;
                    owner_d    = OWN_DATA;
                    wen_d      = bus.data_wen;
                    addr_d     = bus.data_addr;
                    wdata_d    = bus.data_wdata;
                    data_run_d = data_run_next;
                end else if (grant_inst) begin
                    state_d    = ARB_ACC;
                    owner_d    = OWN_INST;
                    wen_d      = '0;
                    addr_d     = bus.inst_addr;
                    wdata_d    = '0;
                    data_run_d = data_run_next;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            // WAIT always spans SRAM_LAT cycles, so the capture edge closes the
            // first cycle in which sram_rdata is valid.
            ARB_ACC: begin
                cnt_d   = CNT_W'(SRAM_LAT - 1);
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (cnt_q == '0) begin
                    cap_d   = bus.sram_rdata;
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    logic in_acc;
    logic inst_ack;
    logic data_ack;

    always_comb begin
        in_acc           = (state_q == ARB_ACC);
        inst_ack         = (state_q == ARB_RESP) && (owner_q == OWN_INST);
        data_ack         = (state_q == ARB_RESP) && (owner_q == OWN_DATA);
        bus.sram_en      = in_acc;
        bus.sram_wen     = in_acc ? wen_q   : '0;
        bus.sram_addr    = in_acc ? addr_q  : '0;
        bus.sram_wdata   = in_acc ? wdata_q : '0;
        bus.inst_ack     = inst_ack;
        bus.data_ack     = data_ack;
        bus.inst_rdata   = inst_ack ? cap_q : '0;
        bus.data_rdata   = data_ack ? cap_q : '0;
        bus.stallreq_if  = bus.inst_req && !inst_ack;
        bus.stallreq_mem = bus.data_req && !data_ack;
        dbg_state        = state_q;
        dbg_data_run     = data_run_q;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: three instances (SRAM_LAT 1, 3, 4)
// each behind a small behavioural fixed-latency SRAM.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();
    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_c ();

    arb_state_e       st_a, st_b, st_c;
    logic [RUN_W-1:0] run_a, run_b, run_c;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(1), .MAX_DATA_RUN(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .dbg_state(st_a), .dbg_data_run(run_a));
    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(3), .MAX_DATA_RUN(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .dbg_state(st_b), .dbg_data_run(run_b));
    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(4), .MAX_DATA_RUN(4)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c.slave), .dbg_state(st_c), .dbg_data_run(run_c));

    // SRAM models: data for an enable in cycle c is presented in cycle c+LAT;
    // outside a valid slot the pipe carries a poison word.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] mem_c [256];
    logic [31:0] pipe_a [1];
    logic [31:0] pipe_b [3];
    logic [31:0] pipe_c [4];

    always @(posedge clk) begin
        pipe_a[0] <= bus_a.sram_en ? mem_a[bus_a.sram_addr[9:2]] : 32'hBAD0BAD0;
        if (bus_a.sram_en)
            for (int i = 0; i < 4; i++)
                if (bus_a.sram_wen[i]) mem_a[bus_a.sram_addr[9:2]][8*i +: 8] <= bus_a.sram_wdata[8*i +: 8];
    end
    always @(posedge clk) begin
        pipe_b[0] <= bus_b.sram_en ? mem_b[bus_b.sram_addr[9:2]] : 32'hBAD0BAD0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        if (bus_b.sram_en)
            for (int i = 0; i < 4; i++)
                if (bus_b.sram_wen[i]) mem_b[bus_b.sram_addr[9:2]][8*i +: 8] <= bus_b.sram_wdata[8*i +: 8];
    end
    always @(posedge clk) begin
        pipe_c[0] <= bus_c.sram_en ? mem_c[bus_c.sram_addr[9:2]] : 32'hBAD0BAD0;
        pipe_c[1] <= pipe_c[0];
        pipe_c[2] <= pipe_c[1];
        pipe_c[3] <= pipe_c[2];
        if (bus_c.sram_en)
            for (int i = 0; i < 4; i++)
                if (bus_c.sram_wen[i]) mem_c[bus_c.sram_addr[9:2]][8*i +: 8] <= bus_c.sram_wdata[8*i +: 8];
    end
    assign bus_a.sram_rdata = pipe_a[0];
    assign bus_b.sram_rdata = pipe_b[2];
    assign bus_c.sram_rdata = pipe_c[3];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        checks++; if (st_a !== ARB_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", st_a); end
        checks++; if (run_a !== 4'd0) begin errors++; $display("FAIL reset_run: got %0d expected 0", run_a); end
        checks++; if ({bus_a.sram_en, bus_a.sram_wen, bus_a.sram_addr, bus_a.sram_wdata} !== 69'd0) begin
            errors++; $display("FAIL reset_sram: got en=%b wen=%h addr=%h wdata=%h expected all 0",
                               bus_a.sram_en, bus_a.sram_wen, bus_a.sram_addr, bus_a.sram_wdata); end
        checks++; if ({bus_a.inst_ack, bus_a.data_ack, bus_a.inst_rdata, bus_a.data_rdata} !== 66'd0) begin
            errors++; $display("FAIL reset_resp: got iack=%b dack=%b irdata=%h drdata=%h expected all 0",
                               bus_a.inst_ack, bus_a.data_ack, bus_a.inst_rdata, bus_a.data_rdata); end
        checks++; if ({bus_a.stallreq_if, bus_a.stallreq_mem} !== 2'b00) begin
            errors++; $display("FAIL reset_stall: got %b expected 00", {bus_a.stallreq_if, bus_a.stallreq_mem}); end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_single_read();
        step();
        bus_a.data_req = 1'b1; bus_a.data_addr = 32'h100; bus_a.data_wen = 4'h0; bus_a.data_wdata = '0;
        #1;
        checks++; if (bus_a.stallreq_mem !== 1'b1) begin errors++; $display("FAIL rd_stall_c0: got %b expected 1", bus_a.stallreq_mem); end
        checks++; if (bus_a.sram_en !== 1'b0) begin errors++; $display("FAIL rd_en_c0: got %b expected 0", bus_a.sram_en); end
        step();
        checks++; if (bus_a.sram_en !== 1'b1) begin errors++; $display("FAIL rd_en_c1: got %b expected 1", bus_a.sram_en); end
        checks++; if (bus_a.sram_addr !== 32'h100) begin errors++; $display("FAIL rd_addr_c1: got %h expected 00000100", bus_a.sram_addr); end
        checks++; if (bus_a.sram_wen !== 4'h0) begin errors++; $display("FAIL rd_wen_c1: got %h expected 0", bus_a.sram_wen); end
        checks++; if (bus_a.stallreq_mem !== 1'b1) begin errors++; $display("FAIL rd_stall_c1: got %b expected 1", bus_a.stallreq_mem); end
        step();
        checks++; if (bus_a.sram_en !== 1'b0) begin errors++; $display("FAIL rd_en_c2: got %b expected 0", bus_a.sram_en); end
        checks++; if (bus_a.stallreq_mem !== 1'b1) begin errors++; $display("FAIL rd_stall_c2: got %b expected 1", bus_a.stallreq_mem); end
        checks++; if (bus_a.data_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_c2: got %b expected 0", bus_a.data_ack); end
        step();
        checks++; if (bus_a.data_ack !== 1'b1) begin errors++; $display("FAIL rd_ack_c3: got %b expected 1", bus_a.data_ack); end
        checks++; if (bus_a.data_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_c3: got %h expected deadbeef", bus_a.data_rdata); end
        checks++; if (bus_a.stallreq_mem !== 1'b0) begin errors++; $display("FAIL rd_stall_c3: got %b expected 0", bus_a.stallreq_mem); end
        checks++; if (bus_a.inst_ack !== 1'b0) begin errors++; $display("FAIL rd_iack_c3: got %b expected 0", bus_a.inst_ack); end
        bus_a.data_req = 1'b0;
        step();
        checks++; if (bus_a.data_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_c4: got %b expected 0", bus_a.data_ack); end
        checks++; if (st_a !== ARB_IDLE) begin errors++; $display("FAIL rd_state_c4: got %0d expected 0", st_a); end
    endtask

    task automatic test_write_read();
        int t0, en1, ack1, ack2;
        logic [3:0]  wen1;
        logic [31:0] wd1, rd;
        en1 = -1; ack1 = -1; ack2 = -1; wen1 = '0; wd1 = '0; rd = '0;
        step();
        bus_b.data_req = 1'b1; bus_b.data_wen = 4'hF; bus_b.data_addr = 32'h20; bus_b.data_wdata = 32'h12345678;
        t0 = cyc;
        for (int k = 0; k < 30 && ack2 < 0; k++) begin
            step();
            if (bus_b.sram_en === 1'b1 && en1 < 0) begin
                en1 = cyc - t0; wen1 = bus_b.sram_wen; wd1 = bus_b.sram_wdata;
            end
            if (bus_b.data_ack === 1'b1) begin
                if (ack1 < 0) begin
                    ack1 = cyc - t0;
                    bus_b.data_wen = 4'h0; bus_b.data_wdata = '0;
                end else begin
                    ack2 = cyc - t0; rd = bus_b.data_rdata;
                    bus_b.data_req = 1'b0;
                end
            end
        end
        bus_b.data_req = 1'b0;
        checks++; if (en1 !== 1) begin errors++; $display("FAIL wr_en_cycle: got %0d expected 1", en1); end
        checks++; if (wen1 !== 4'hF) begin errors++; $display("FAIL wr_wen: got %h expected f", wen1); end
        checks++; if (wd1 !== 32'h12345678) begin errors++; $display("FAIL wr_wdata: got %h expected 12345678", wd1); end
        checks++; if (ack1 !== 5) begin errors++; $display("FAIL wr_ack_cycle: got %0d expected 5", ack1); end
        checks++; if (ack2 - ack1 !== 5) begin errors++; $display("FAIL wr_rd_ack_spacing: got %0d expected 5 (ack2=%0d)", ack2 - ack1, ack2); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL wr_rd_data: got %h expected 12345678", rd); end
        step(); step();
        checks++; if (st_b !== ARB_IDLE) begin errors++; $display("FAIL wr_idle_after: got %0d expected 0", st_b); end
    endtask

    task automatic test_contention();
        int  n, last;
        logic got_inst, exp_inst;
        n = 0; last = -1;
        step();
        bus_a.inst_req = 1'b1; bus_a.inst_addr = 32'h40;
        bus_a.data_req = 1'b1; bus_a.data_addr = 32'h80; bus_a.data_wen = 4'h0; bus_a.data_wdata = '0;
        for (int k = 0; k < 80 && n < 10; k++) begin
            step();
            if (bus_a.inst_ack === 1'b1) begin
                checks++; if (bus_a.inst_rdata !== 32'h11110040) begin errors++; $display("FAIL cont_irdata: got %h expected 11110040", bus_a.inst_rdata); end
            end
            if (bus_a.data_ack === 1'b1) begin
                checks++; if (bus_a.data_rdata !== 32'h22220080) begin errors++; $display("FAIL cont_drdata: got %h expected 22220080", bus_a.data_rdata); end
            end
            if (bus_a.sram_en === 1'b1) begin
                got_inst = (bus_a.sram_addr == 32'h40);
                exp_inst = (n % 5 == 4);
                checks++; if (got_inst !== exp_inst) begin errors++; $display("FAIL cont_order[%0d]: got inst=%b expected inst=%b", n, got_inst, exp_inst); end
                if (n > 0) begin
                    checks++; if (cyc - last !== 3) begin errors++; $display("FAIL cont_spacing[%0d]: got %0d expected 3", n, cyc - last); end
                end
                if (n == 3) begin
                    checks++; if (run_a !== 4'd4) begin errors++; $display("FAIL cont_run_full: got %0d expected 4", run_a); end
                end
                if (n == 4) begin
                    checks++; if (run_a !== 4'd0) begin errors++; $display("FAIL cont_run_clear: got %0d expected 0", run_a); end
                end
                last = cyc;
                n++;
            end
        end
        checks++; if (n !== 10) begin errors++; $display("FAIL cont_grant_count: got %0d expected 10", n); end
        bus_a.inst_req = 1'b0; bus_a.data_req = 1'b0;
        for (int k = 0; k < 10 && st_a != ARB_IDLE; k++) step();
        checks++; if (st_a !== ARB_IDLE) begin errors++; $display("FAIL cont_drain: got %0d expected 0", st_a); end
    endtask

    task automatic test_flush();
        int extra;
        extra = 0;
        step();
        bus_a.inst_req = 1'b1; bus_a.inst_addr = 32'h44;
        #1;
        checks++; if (bus_a.stallreq_if !== 1'b1) begin errors++; $display("FAIL fl_stall_c0: got %b expected 1", bus_a.stallreq_if); end
        step();
        checks++; if ({bus_a.sram_en, bus_a.sram_addr} !== {1'b1, 32'h44}) begin
            errors++; $display("FAIL fl_acc_c1: got en=%b addr=%h expected en=1 addr=00000044", bus_a.sram_en, bus_a.sram_addr); end
        bus_a.inst_req = 1'b0;
        #1;
        checks++; if (bus_a.stallreq_if !== 1'b0) begin errors++; $display("FAIL fl_stall_drop: got %b expected 0", bus_a.stallreq_if); end
        step();
        step();
        checks++; if (bus_a.inst_ack !== 1'b1) begin errors++; $display("FAIL fl_ack_c3: got %b expected 1", bus_a.inst_ack); end
        checks++; if (bus_a.inst_rdata !== 32'hCAFE0044) begin errors++; $display("FAIL fl_data_c3: got %h expected cafe0044", bus_a.inst_rdata); end
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus_a.sram_en !== 1'b0 || bus_a.inst_ack !== 1'b0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL fl_no_reissue: got %0d busy cycles expected 0", extra); end
        checks++; if (st_a !== ARB_IDLE) begin errors++; $display("FAIL fl_idle: got %0d expected 0", st_a); end
    endtask

    task automatic test_reset_in_wait();
        int t0, got, stray;
        logic [31:0] rd;
        got = -1; stray = 0; rd = '0;
        step();
        bus_c.data_req = 1'b1; bus_c.data_addr = 32'h8; bus_c.data_wen = 4'h0; bus_c.data_wdata = '0;
        step();
        checks++; if (bus_c.sram_en !== 1'b1) begin errors++; $display("FAIL rw_acc_c1: got %b expected 1", bus_c.sram_en); end
        step();
        checks++; if (st_c !== ARB_WAIT) begin errors++; $display("FAIL rw_wait_c2: got %0d expected 2", st_c); end
        #3 rst = 1'b0;
        bus_c.data_req = 1'b0;
        #1;
        checks++; if (st_c !== ARB_IDLE) begin errors++; $display("FAIL rw_state: got %0d expected 0", st_c); end
        checks++; if ({bus_c.sram_en, bus_c.data_ack, bus_c.inst_ack} !== 3'b000) begin
            errors++; $display("FAIL rw_ctrl: got en=%b dack=%b iack=%b expected all 0", bus_c.sram_en, bus_c.data_ack, bus_c.inst_ack); end
        checks++; if ({bus_c.data_rdata, bus_c.inst_rdata} !== 64'd0) begin
            errors++; $display("FAIL rw_rdata: got %h/%h expected 0", bus_c.data_rdata, bus_c.inst_rdata); end
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus_c.data_ack !== 1'b0 || bus_c.sram_en !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rw_aborted: got %0d busy cycles expected 0", stray); end
        step();
        bus_c.data_req = 1'b1; bus_c.data_addr = 32'hC;
        t0 = cyc;
        for (int k = 0; k < 20 && got < 0; k++) begin
            step();
            if (bus_c.data_ack === 1'b1) begin
                got = cyc - t0; rd = bus_c.data_rdata; bus_c.data_req = 1'b0;
            end
        end
        bus_c.data_req = 1'b0;
        checks++; if (got !== 6) begin errors++; $display("FAIL rw_fresh_latency: got %0d expected 6", got); end
        checks++; if (rd !== 32'h600DF00D) begin errors++; $display("FAIL rw_fresh_data: got %h expected 600df00d", rd); end
    endtask

    task automatic test_idle();
        int busy;
        busy = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus_a.sram_en !== 1'b0) busy++;
        end
        checks++; if (busy !== 0) begin errors++; $display("FAIL idle_en: got %0d enabled cycles expected 0", busy); end
        checks++; if (run_a !== 4'd0) begin errors++; $display("FAIL idle_run: got %0d expected 0", run_a); end
        checks++; if (st_a !== ARB_IDLE) begin errors++; $display("FAIL idle_state: got %0d expected 0", st_a); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h0; mem_b[i] = 32'h0; mem_c[i] = 32'h0;
        end
        mem_a[64] = 32'hDEADBEEF;
        mem_a[16] = 32'h11110040;
        mem_a[17] = 32'hCAFE0044;
        mem_a[32] = 32'h22220080;
        mem_c[2]  = 32'h0BADF00D;
        mem_c[3]  = 32'h600DF00D;
        bus_a.inst_req = 1'b0; bus_a.inst_addr = '0; bus_a.data_req = 1'b0;
        bus_a.data_wen = '0; bus_a.data_addr = '0; bus_a.data_wdata = '0;
        bus_b.inst_req = 1'b0; bus_b.inst_addr = '0; bus_b.data_req = 1'b0;
        bus_b.data_wen = '0; bus_b.data_addr = '0; bus_b.data_wdata = '0;
        bus_c.inst_req = 1'b0; bus_c.inst_addr = '0; bus_c.data_req = 1'b0;
        bus_c.data_wen = '0; bus_c.data_addr = '0; bus_c.data_wdata = '0;

        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_flush();
        test_reset_in_wait();
        test_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
